enc8to3_serial: RTL and testbench



---
 rtl/enc_pkg.sv | 15 +
 rtl/pri_enc8.sv | 33 +++
 rtl/enc8to3_serial.sv | 119 +++++++++++
 tb/tb_enc8to3_serial.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared definitions for the serial 8-to-3 encoder.
//   N_LINES     : number of request lines (fixed at 8)
//   CODE_W      : width of a line code, clog2(N_LINES)
//   enc_state_e : drain FSM states (ENC_IDLE: nothing pending, ENC_DRAIN: lines pending)
package enc_pkg;

  localparam int unsigned N_LINES = 8;
  localparam int unsigned CODE_W  = 3;

  typedef enum logic {
    ENC_IDLE  = 1'b0,
    ENC_DRAIN = 1'b1
  } enc_state_e;

endpackage

// File: rtl/pri_enc8.sv
// First-set-bit finder over 8 request lines with a rotating start index.
// The search begins at line `start` and wraps from 7 back to 0; the first set
// line found is reported.
//   lines : request lines, lines[i] set means line i is a candidate
//   start : line index where the search begins (0 gives plain lowest-index priority)
//   code  : index of the selected line, 0 when no line is set
//   any   : at least one line is set
module pri_enc8
  import enc_pkg::*;
(
  input  logic [0:N_LINES-1] lines,
  input  logic [CODE_W-1:0]  start,
  output logic [CODE_W-1:0]  code,
  output logic               any
);

  logic [CODE_W-1:0] idx;

  always_comb begin
    code = '0;
    any  = 1'b0;
    idx  = '0;
    for (int unsigned i = 0; i < N_LINES; i++) begin
      // CODE_W-bit addition gives the modulo-8 wrap for free
      idx = start + i[CODE_W-1:0];
      if (!any && lines[idx]) begin
        any  = 1'b1;
        code = idx;
      end
    end
  end

endmodule

// File: rtl/enc8to3_serial.sv
// Sequential 8-to-3 encoder. Captures a multi-hot request vector into a pending
// set and presents one 3-bit line code per cycle over a valid/ready handshake,
// clearing each line once accepted. `done` pulses in the cycle after the last
// pending line is accepted.
//
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   en    : block enable; 0 freezes all state and forces valid/done low
//   load  : merge y into the pending set this cycle
//   y     : request lines, y[i] requests code i
//   w     : code of the currently presented line
//   valid : w is meaningful
//   ready : consumer accepts w when valid && ready
//   done  : one-cycle pulse after the final pending line is accepted
//
// Configuration macro ENC8TO3_RR_EN: when defined, selection is round-robin
// starting from a pointer that advances past each accepted line; otherwise the
// lowest set index is always selected and no pointer register exists.
module enc8to3_serial
  import enc_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               load,
  input  logic [0:N_LINES-1] y,
  output logic [CODE_W-1:0]  w,
  output logic               valid,
  input  logic               ready,
  output logic               done
);

  enc_state_e         state, state_nxt;
  logic [0:N_LINES-1] pend, pend_nxt, cleared;
  logic [CODE_W-1:0]  start, sel_code;
  logic               sel_any, accept;
  logic               done_q, done_nxt;

`ifdef ENC8TO3_RR_EN
  logic [CODE_W-1:0] ptr;

  // Pointer moves one past the accepted line; 3-bit arithmetic wraps 7 to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= sel_code + CODE_W'(1);
    end
  end

  assign start = ptr;
`else
  assign start = '0;
`endif

  pri_enc8 u_pri (
    .lines (pend),
    .start (start),
    .code  (sel_code),
    .any   (sel_any)
  );

  assign w      = sel_code;
  assign valid  = (state == ENC_DRAIN) && en;
  assign accept = valid && ready;
  assign done   = done_q && en;

  always_comb begin
    cleared   = '0;
    pend_nxt  = pend;
    state_nxt = state;
    done_nxt  = 1'b0;

    if (en) begin
      if (accept && sel_any) begin
        cleared[sel_code] = 1'b1;
      end
      // Clear before merging so a line accepted and re-loaded in the same
      // cycle stays pending.
      pend_nxt = pend & ~cleared;
      if (load) begin
        pend_nxt = pend_nxt | y;
      end

      case (state)
        ENC_IDLE: begin
          if (pend_nxt != '0) begin
            state_nxt = ENC_DRAIN;
          end
        end
        ENC_DRAIN: begin
          if (pend_nxt == '0) begin
            state_nxt = ENC_IDLE;
            done_nxt  = accept;
          end
        end
        default: state_nxt = ENC_IDLE;
      endcase
    end
  end

  // done_q is a pulse register rather than pending state: it is allowed to
  // clear while en is low so a pulse masked by en=0 does not reappear later.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ENC_IDLE;
      pend   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= done_nxt;
      if (en) begin
        state <= state_nxt;
        pend  <= pend_nxt;
      end
    end
  end

endmodule

// File: tb/tb_enc8to3_serial.sv
// Self-checking bench for enc8to3_serial: directed scenarios with fixed
// expected output sequences plus a randomized run checked against a
// behavioural model of the pending set.
module tb_enc8to3_serial;

  logic       clk = 1'b0;
  logic       rst, en, load, ready;
  logic [0:7] y;
  logic [2:0] w;
  logic       valid, done;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  enc8to3_serial dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .load  (load),
    .y     (y),
    .w     (w),
    .valid (valid),
    .ready (ready),
    .done  (done)
  );

  // Behavioural model: set of pending line numbers, search pointer, done flag
  bit   m_pend[8];
  int   m_ptr;
  bit   m_done;
  logic exp_valid;
  logic [2:0] exp_w;
  logic exp_done;

  function automatic int pick();
    for (int k = 0; k < 8; k++) begin
      int idx;
      idx = (m_ptr + k) % 8;
      if (m_pend[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic bit any_pending();
    for (int k = 0; k < 8; k++) if (m_pend[k]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic expect_now();
    int s;
    s = pick();
    exp_valid = en && (s >= 0);
    exp_w     = (s >= 0) ? 3'(s) : 3'd0;
    exp_done  = en && m_done;
  endtask

  task automatic drive(input logic r, input logic e, input logic l,
                       input logic [0:7] yy, input logic rd);
    rst = r; en = e; load = l; y = yy; ready = rd;
    #1;
    expect_now();
  endtask

  task automatic tick();
    int s;
    bit acc;
    s = pick();
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < 8; k++) m_pend[k] = 1'b0;
      m_ptr  = 0;
      m_done = 1'b0;
    end else if (!en) begin
      m_done = 1'b0;
    end else begin
      acc = (s >= 0) && ready;
      if (acc) begin
        m_pend[s] = 1'b0;
`ifdef ENC8TO3_RR_EN
        m_ptr = (s + 1) % 8;
`endif
      end
      if (load) for (int k = 0; k < 8; k++) m_pend[k] = m_pend[k] | y[k];
      m_done = acc && !any_pending();
    end
    #1;
  endtask

  task automatic apply_reset();
    drive(1'b1, 1'b1, 1'b0, '0, 1'b0);
    tick();
  endtask

  task automatic test_reset();
    logic [4:0] exp;
    drive(1'b1, 1'b1, 1'b1, 8'hFF, 1'b1);
    tick();
    drive(1'b0, 1'b1, 1'b0, '0, 1'b1);
    exp = 5'b0_000_0;
    n_checks++;
    if ({valid, w, done} !== exp)
      $display("FAIL reset {valid,w,done}=%b expected %b", {valid, w, done}, exp);
    else n_pass++;
  endtask

  task automatic test_two_lines();
    logic [4:0] exp [5];
    exp = '{5'b0_000_0, 5'b1_010_0, 5'b1_101_0, 5'b0_000_1, 5'b0_000_0};
    apply_reset();
    for (int c = 0; c < 5; c++) begin
      if (c == 0) drive(1'b0, 1'b1, 1'b1, 8'b0010_0100, 1'b1);
      else        drive(1'b0, 1'b1, 1'b0, '0, 1'b1);
      n_checks++;
      if ({valid, w, done} !== exp[c])
        $display("FAIL two_lines c%0d {valid,w,done}=%b expected %b", c, {valid, w, done}, exp[c]);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] exp;
    apply_reset();
    for (int c = 0; c < 11; c++) begin
      if (c == 0) drive(1'b0, 1'b1, 1'b1, 8'hFF, 1'b1);
      else        drive(1'b0, 1'b1, 1'b0, '0, 1'b1);
      if (c == 0)       exp = 5'b0_000_0;
      else if (c <= 8)  exp = {1'b1, 3'(c - 1), 1'b0};
      else if (c == 9)  exp = 5'b0_000_1;
      else              exp = 5'b0_000_0;
      n_checks++;
      if ({valid, w, done} !== exp)
        $display("FAIL back_to_back c%0d {valid,w,done}=%b expected %b", c, {valid, w, done}, exp);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_stall();
    logic [4:0] exp;
    apply_reset();
    for (int c = 0; c < 9; c++) begin
      if (c == 0)      drive(1'b0, 1'b1, 1'b1, 8'b0001_0000, 1'b0);
      else if (c <= 5) drive(1'b0, 1'b1, 1'b0, '0, 1'b0);
      else             drive(1'b0, 1'b1, 1'b0, '0, 1'b1);
      if (c == 0)      exp = 5'b0_000_0;
      else if (c <= 6) exp = 5'b1_011_0;
      else if (c == 7) exp = 5'b0_000_1;
      else             exp = 5'b0_000_0;
      n_checks++;
      if ({valid, w, done} !== exp)
        $display("FAIL stall c%0d {valid,w,done}=%b expected %b", c, {valid, w, done}, exp);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_enable();
    logic [4:0] exp;
    apply_reset();
    exp = 5'b0_000_0;
    for (int c = 0; c < 5; c++) begin
      if (c < 2) drive(1'b0, 1'b0, 1'b1, 8'hFF, 1'b1);
      else       drive(1'b0, 1'b1, 1'b0, '0, 1'b1);
      n_checks++;
      if ({valid, w, done} !== exp)
        $display("FAIL enable c%0d {valid,w,done}=%b expected %b", c, {valid, w, done}, exp);
      else n_pass++;
      tick();
    end
    // Freeze mid-drain: valid drops, w holds, draining resumes afterwards
    drive(1'b0, 1'b1, 1'b1, 8'b0100_0100, 1'b1);
    tick();
    for (int c = 0; c < 6; c++) begin
      if (c < 3) drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
      else       drive(1'b0, 1'b1, 1'b0, '0, 1'b1);
      if (c < 3)       exp = 5'b0_001_0;
      else if (c == 3) exp = 5'b1_001_0;
      else if (c == 4) exp = 5'b1_101_0;
      else             exp = 5'b0_000_1;
      n_checks++;
      if ({valid, w, done} !== exp)
        $display("FAIL enable_freeze c%0d {valid,w,done}=%b expected %b", c, {valid, w, done}, exp);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_reload();
    logic [4:0] exp [5];
`ifdef ENC8TO3_RR_EN
    exp = '{5'b0_000_0, 5'b1_001_0, 5'b1_110_0, 5'b1_001_0, 5'b0_000_1};
`else
    exp = '{5'b0_000_0, 5'b1_001_0, 5'b1_001_0, 5'b1_110_0, 5'b0_000_1};
`endif
    apply_reset();
    for (int c = 0; c < 5; c++) begin
      if (c == 0)      drive(1'b0, 1'b1, 1'b1, 8'b0100_0010, 1'b1);
      else if (c == 1) drive(1'b0, 1'b1, 1'b1, 8'b0100_0000, 1'b1);
      else             drive(1'b0, 1'b1, 1'b0, '0, 1'b1);
      n_checks++;
      if ({valid, w, done} !== exp[c])
        $display("FAIL reload c%0d {valid,w,done}=%b expected %b", c, {valid, w, done}, exp[c]);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_reset_mid_drain();
    logic [4:0] exp;
    apply_reset();
    for (int c = 0; c < 6; c++) begin
      if (c == 0)      drive(1'b0, 1'b1, 1'b1, 8'b1010_1010, 1'b1);
      else if (c == 2) drive(1'b1, 1'b1, 1'b0, '0, 1'b1);
      else             drive(1'b0, 1'b1, 1'b0, '0, 1'b1);
      if (c == 1)      exp = 5'b1_000_0;
      else if (c == 2) exp = 5'b1_010_0;
      else             exp = 5'b0_000_0;
      n_checks++;
      if ({valid, w, done} !== exp)
        $display("FAIL reset_mid_drain c%0d {valid,w,done}=%b expected %b", c, {valid, w, done}, exp);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      drive(($urandom % 64) == 0, ($urandom % 8) != 0, ($urandom % 4) == 0,
            8'($urandom), ($urandom % 3) != 0);
      n_checks++;
      if ({valid, w, done} !== {exp_valid, exp_w, exp_done})
        $display("FAIL random c%0d {valid,w,done}=%b expected %b",
                 c, {valid, w, done}, {exp_valid, exp_w, exp_done});
      else n_pass++;
      tick();
    end
  endtask

  initial begin
    for (int k = 0; k < 8; k++) m_pend[k] = 1'b0;
    m_ptr  = 0;
    m_done = 1'b0;
    test_reset();
    test_two_lines();
    test_back_to_back();
    test_stall();
    test_enable();
    test_reload();
    test_reset_mid_drain();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
